// File: rtl/doe_pkg.sv
// Shared definitions for the DOE counter blocks: BCD digit limits,
// FSM state encodings and the per-digit clamp helper.
package doe_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Non-BCD nibbles (A..F) saturate to 9 so a digit never leaves 0..9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade of the down-counter: loads a clamped preset, or steps down
// when a borrow arrives, rolling 0 -> 9 and passing the borrow onward.
module bcd_down_digit
    import doe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= BCD_ZERO;
        end else if (load) begin
            digit <= bcd_clamp(load_digit);
        end else if (borrow_in) begin
            digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
        end
    end

    assign borrow_out = borrow_in && (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Cascadable, loadable BCD down-counter with zero flag, underflow borrow
// pulse and (when WRAP=0) a sticky expired flag that halts at zero.
module bcd_down_counter
    import doe_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                in,
    output logic [4*DIGITS-1:0] cnt,
    output logic                zero,
    output logic                borrow,
    output logic                expired
);

    localparam int W = 4 * DIGITS;

    state_t            state;
    state_t            state_next;
    logic [DIGITS:0]   borrow_chain;
    logic              dec;
    logic              underflow;
    logic              cnt_is_one;
    logic              load_is_zero;
    logic              zero_next;

    // Without WRAP the counter never decrements from zero; HALT covers that case.
    assign dec          = (state == RUN) && in && !load && (WRAP || !zero);
    assign borrow_chain[0] = dec;
    assign underflow    = borrow_chain[DIGITS];
    assign cnt_is_one   = (cnt == W'(1));
    assign load_is_zero = (load_val == '0);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load),
            .load_digit (load_val[4*k +: 4]),
            .borrow_in  (borrow_chain[k]),
            .digit      (cnt[4*k +: 4]),
            .borrow_out (borrow_chain[k+1])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RUN: begin
                if (load) begin
                    state_next = (!WRAP && load_is_zero) ? HALT : RUN;
                end else if (!WRAP && dec && cnt_is_one) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (load && !load_is_zero) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A clamped load is zero only if the raw preset is zero; a decrement lands on zero only from one.
    assign zero_next = load ? load_is_zero : (dec ? cnt_is_one : zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            zero    <= 1'b1;
            borrow  <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_next;
            zero    <= zero_next;
            borrow  <= underflow;
            expired <= (state_next == HALT);
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench: three counter configurations run in lockstep against
// an integer-valued reference model, with directed steps then random traffic.
module tb_bcd_down_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic        in;
    logic [7:0]  lv2;
    logic [11:0] lv3;

    logic [7:0]  cnt_a, cnt_b;
    logic [11:0] cnt_c;
    logic        zero_a, zero_b, zero_c;
    logic        borrow_a, borrow_b, borrow_c;
    logic        expired_a, expired_b, expired_c;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, one entry per configuration (a: 2/wrap, b: 2/stop, c: 3/wrap)
    int m_digits [3] = '{2, 2, 3};
    bit m_wrap   [3] = '{1'b1, 1'b0, 1'b1};
    int m_value  [3];
    bit m_loaded [3];
    bit m_halted [3];
    bit m_borrow [3];
    bit m_expired[3];

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(lv2), .in(in),
        .cnt(cnt_a), .zero(zero_a), .borrow(borrow_a), .expired(expired_a));

    bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(lv2), .in(in),
        .cnt(cnt_b), .zero(zero_b), .borrow(borrow_b), .expired(expired_b));

    bcd_down_counter #(.DIGITS(3), .WRAP(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(lv3), .in(in),
        .cnt(cnt_c), .zero(zero_c), .borrow(borrow_c), .expired(expired_c));

    function automatic int pow10(int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic int preset_value(logic [15:0] lv, int d);
        int v = 0;
        for (int k = 0; k < d; k++) begin
            int nib = int'((lv >> (4 * k)) & 16'hF);
            if (nib > 9) nib = 9;
            v = v + nib * pow10(k);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = '0;
        for (int k = 0; k < 4; k++) begin
            r = r | (16'((v / pow10(k)) % 10) << (4 * k));
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            m_value[n] = 0; m_loaded[n] = 0; m_halted[n] = 0;
            m_borrow[n] = 0; m_expired[n] = 0;
        end
    endtask

    task automatic model_step(int n, logic [15:0] lv);
        m_borrow[n] = 0;
        if (load) begin
            m_value[n]   = preset_value(lv, m_digits[n]);
            m_loaded[n]  = 1;
            m_halted[n]  = !m_wrap[n] && (m_value[n] == 0);
            m_expired[n] = m_halted[n];
        end else if (in && m_loaded[n] && !m_halted[n]) begin
            if (m_value[n] == 0) begin
                m_value[n]  = pow10(m_digits[n]) - 1;
                m_borrow[n] = 1;
            end else begin
                m_value[n] = m_value[n] - 1;
                if (!m_wrap[n] && m_value[n] == 0) begin
                    m_halted[n]  = 1;
                    m_expired[n] = 1;
                end
            end
        end
    endtask

    task automatic cmp(string name, logic [15:0] obs, logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_output(string tag);
        cmp({tag, " a.cnt"},     {8'h0, cnt_a},    to_bcd(m_value[0]));
        cmp({tag, " a.zero"},    16'(zero_a),      16'(m_value[0] == 0));
        cmp({tag, " a.borrow"},  16'(borrow_a),    16'(m_borrow[0]));
        cmp({tag, " a.expired"}, 16'(expired_a),   16'(m_expired[0]));
        cmp({tag, " b.cnt"},     {8'h0, cnt_b},    to_bcd(m_value[1]));
        cmp({tag, " b.zero"},    16'(zero_b),      16'(m_value[1] == 0));
        cmp({tag, " b.borrow"},  16'(borrow_b),    16'(m_borrow[1]));
        cmp({tag, " b.expired"}, 16'(expired_b),   16'(m_expired[1]));
        cmp({tag, " c.cnt"},     {4'h0, cnt_c},    to_bcd(m_value[2]));
        cmp({tag, " c.zero"},    16'(zero_c),      16'(m_value[2] == 0));
        cmp({tag, " c.borrow"},  16'(borrow_c),    16'(m_borrow[2]));
        cmp({tag, " c.expired"}, 16'(expired_c),   16'(m_expired[2]));
    endtask

    task automatic apply_stimulus(string tag, logic l, logic i, logic [7:0] v2, logic [11:0] v3);
        @(negedge clk);
        load = l; in = i; lv2 = v2; lv3 = v3;
        @(posedge clk);
        model_step(0, {8'h0, v2});
        model_step(1, {8'h0, v2});
        model_step(2, {4'h0, v3});
        #1;
        check_output(tag);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; in = 1'b0; lv2 = '0; lv3 = '0;
        model_reset();
        #12;
        check_output("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE: count enable ignored before the first load
        for (int k = 0; k < 3; k++) apply_stimulus("idle", 1'b0, 1'(k % 2 == 0), 8'h55, 12'h555);

        // Load 23 / 100 then count across a decade boundary
        apply_stimulus("load23", 1'b1, 1'b0, 8'h23, 12'h100);
        for (int k = 0; k < 4; k++) apply_stimulus("count", 1'b0, 1'b1, 8'h00, 12'h000);

        // Underflow: wrap to nines on a/c, halt with expired on b
        apply_stimulus("load01", 1'b1, 1'b0, 8'h01, 12'h001);
        for (int k = 0; k < 3; k++) apply_stimulus("wrap", 1'b0, 1'b1, 8'h00, 12'h000);

        // Stop at zero, then reload a nonzero value to clear expired
        apply_stimulus("load02", 1'b1, 1'b0, 8'h02, 12'h002);
        for (int k = 0; k < 4; k++) apply_stimulus("stop", 1'b0, 1'b1, 8'h00, 12'h000);
        apply_stimulus("load05", 1'b1, 1'b0, 8'h05, 12'h005);

        // Load of zero, then load beats count with per-digit clamping
        apply_stimulus("load00", 1'b1, 1'b1, 8'h00, 12'h000);
        apply_stimulus("zero_in", 1'b0, 1'b1, 8'h00, 12'h000);
        apply_stimulus("clamp", 1'b1, 1'b1, 8'hA3, 12'hFA3);

        // Count to 47 then drop reset between edges
        apply_stimulus("load48", 1'b1, 1'b0, 8'h48, 12'h048);
        apply_stimulus("to47", 1'b0, 1'b1, 8'h00, 12'h000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus("post_reset", 1'b0, 1'b1, 8'h00, 12'h000);

        // Random traffic with small presets mixed in so zero and underflow recur
        for (int k = 0; k < 400; k++) begin
            logic       l, i;
            logic [7:0]  v2;
            logic [11:0] v3;
            l  = ($urandom_range(0, 7) == 0);
            i  = ($urandom_range(0, 3) != 0);
            v2 = 8'($urandom);
            v3 = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                v2 = 8'($urandom_range(0, 3));
                v3 = 12'($urandom_range(0, 3));
            end
            apply_stimulus("random", l, i, v2, v3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
